// File: rtl/jtag_types_pkg.sv
// Shared JTAG TAP types: 16-state TAP encoding and instruction opcodes.
package jtag_types_pkg;

    typedef enum logic [3:0] {
        TLR    = 4'h0,
        RTI    = 4'h1,
        SEL_DR = 4'h2,
        CAP_DR = 4'h3,
        SH_DR  = 4'h4,
        EX1_DR = 4'h5,
        PAU_DR = 4'h6,
        EX2_DR = 4'h7,
        UPD_DR = 4'h8,
        SEL_IR = 4'h9,
        CAP_IR = 4'hA,
        SH_IR  = 4'hB,
        EX1_IR = 4'hC,
        PAU_IR = 4'hD,
        EX2_IR = 4'hE,
        UPD_IR = 4'hF
    } tap_state_t;

    // Opcodes; BYPASS is all ones and is truncated to the IR width at use.
    localparam int unsigned OP_EXTEST         = 0;
    localparam int unsigned OP_SAMPLE_PRELOAD = 1;
    localparam int unsigned OP_IDCODE         = 2;
    localparam logic [31:0] OP_BYPASS         = '1;

    // True for the states in which TDO is sourced from the instruction register.
    function automatic logic is_ir_path(input tap_state_t s);
        return (s == CAP_IR) || (s == SH_IR)  || (s == EX1_IR) ||
               (s == PAU_IR) || (s == EX2_IR) || (s == UPD_IR);
    endfunction

endpackage

// File: rtl/tap_fsm.sv
// IEEE 1149.1 TAP state machine: state register, TMS next-state logic and
// DR strobe / Test-Logic-Reset decode.
module tap_fsm
    import jtag_types_pkg::*;
(
    input  logic       i_tck,
    input  logic       i_trst,
    input  logic       i_tms,
    output tap_state_t o_state,
    output tap_state_t o_next,
    output logic       o_dr_capture,
    output logic       o_dr_shift,
    output logic       o_dr_update,
    output logic       o_tlr
);

    tap_state_t r_state;
    tap_state_t w_next;

    // Standard TMS-driven transition table.
    always_comb begin
        w_next = TLR;
        case (r_state)
            TLR:     w_next = i_tms ? TLR    : RTI;
            RTI:     w_next = i_tms ? SEL_DR : RTI;
            SEL_DR:  w_next = i_tms ? SEL_IR : CAP_DR;
            CAP_DR:  w_next = i_tms ? EX1_DR : SH_DR;
            SH_DR:   w_next = i_tms ? EX1_DR : SH_DR;
            EX1_DR:  w_next = i_tms ? UPD_DR : PAU_DR;
            PAU_DR:  w_next = i_tms ? EX2_DR : PAU_DR;
            EX2_DR:  w_next = i_tms ? UPD_DR : SH_DR;
            UPD_DR:  w_next = i_tms ? SEL_DR : RTI;
            SEL_IR:  w_next = i_tms ? TLR    : CAP_IR;
            CAP_IR:  w_next = i_tms ? EX1_IR : SH_IR;
            SH_IR:   w_next = i_tms ? EX1_IR : SH_IR;
            EX1_IR:  w_next = i_tms ? UPD_IR : PAU_IR;
            PAU_IR:  w_next = i_tms ? EX2_IR : PAU_IR;
            EX2_IR:  w_next = i_tms ? UPD_IR : SH_IR;
            UPD_IR:  w_next = i_tms ? SEL_DR : RTI;
            default: w_next = TLR;
        endcase
    end

    // State register; TRST overrides TMS.
    always_ff @(posedge i_tck) begin
        if (i_trst) begin
            r_state <= TLR;
        end else begin
            r_state <= w_next;
        end
    end

    assign o_state      = r_state;
    assign o_next       = i_trst ? TLR : w_next;
    assign o_dr_capture = (r_state == CAP_DR);
    assign o_dr_shift   = (r_state == SH_DR);
    assign o_dr_update  = (r_state == UPD_DR);
    assign o_tlr        = (r_state == TLR);

endmodule

// File: rtl/tap_ctrl.sv
// JTAG TAP controller: TAP FSM, instruction register and instruction decode.
// Define TAP_IDCODE_EN to decode IDCODE and make it the reset instruction;
// otherwise opcode 0x2 decodes as BYPASS and BYPASS is the reset instruction.
module tap_ctrl
    import jtag_types_pkg::*;
#(
    parameter int unsigned IR_WIDTH = 4
) (
    input  logic                TCK,
    input  logic                TRST,
    input  logic                TMS,
    input  logic                TDI,
    output logic                dr_capture,
    output logic                dr_shift,
    output logic                dr_update,
    output logic                ir_tdo,
    output logic                tdo_sel,
    output logic                bsr_select,
    output logic                bypass_select,
    output logic                idcode_select,
    output logic                mode,
    output logic                tlr_reset,
    output logic [IR_WIDTH-1:0] ir_out
);

    localparam logic [IR_WIDTH-1:0] C_BYPASS  = IR_WIDTH'(OP_BYPASS);
    localparam logic [IR_WIDTH-1:0] C_CAPTURE = IR_WIDTH'(1);
`ifdef TAP_IDCODE_EN
    localparam logic [IR_WIDTH-1:0] C_RST_IR  = IR_WIDTH'(OP_IDCODE);
`else
    localparam logic [IR_WIDTH-1:0] C_RST_IR  = C_BYPASS;
`endif

    tap_state_t          w_state;
    tap_state_t          w_next;
    logic [IR_WIDTH-1:0] r_ir_shift;
    logic [IR_WIDTH-1:0] r_ir;
    logic                w_bsr;
    logic                w_byp;
    logic                w_idc;
    logic                w_mode;

    tap_fsm u_fsm (
        .i_tck        (TCK),
        .i_trst       (TRST),
        .i_tms        (TMS),
        .o_state      (w_state),
        .o_next       (w_next),
        .o_dr_capture (dr_capture),
        .o_dr_shift   (dr_shift),
        .o_dr_update  (dr_update),
        .o_tlr        (tlr_reset)
    );

    // IR shift register and active instruction; entry into TLR (by TRST or
    // by TMS) reloads the reset instruction and discards any pending shift.
    always_ff @(posedge TCK) begin
        if (TRST) begin
            r_ir_shift <= C_CAPTURE;
            r_ir       <= C_RST_IR;
        end else begin
            case (w_state)
                CAP_IR:  r_ir_shift <= C_CAPTURE;
                SH_IR:   r_ir_shift <= {TDI, r_ir_shift[IR_WIDTH-1:1]};
                UPD_IR:  r_ir       <= r_ir_shift;
                default: ;
            endcase
            if (w_next == TLR) begin
                r_ir <= C_RST_IR;
            end
        end
    end

    // One-hot data-register select decoded from the active instruction.
    always_comb begin
        w_bsr  = 1'b0;
        w_byp  = 1'b0;
        w_idc  = 1'b0;
        w_mode = 1'b0;
        case (r_ir)
            IR_WIDTH'(OP_EXTEST): begin
                w_bsr  = 1'b1;
                w_mode = 1'b1;
            end
            IR_WIDTH'(OP_SAMPLE_PRELOAD): w_bsr = 1'b1;
`ifdef TAP_IDCODE_EN
            IR_WIDTH'(OP_IDCODE):         w_idc = 1'b1;
`endif
            default:                      w_byp = 1'b1;
        endcase
    end

    assign ir_tdo        = r_ir_shift[0];
    assign tdo_sel       = is_ir_path(w_state);
    assign bsr_select    = w_bsr;
    assign bypass_select = w_byp;
    assign idcode_select = w_idc;
    assign mode          = w_mode;
    assign ir_out        = r_ir;

endmodule

// File: tb/tb_tap_ctrl.sv
// Scoreboard bench for tap_ctrl: driver runs a reference TAP model and queues
// expected outputs; a monitor compares them after each rising TCK edge.
module tb_tap_ctrl;
    import jtag_types_pkg::*;

    localparam int W = 4;
`ifdef TAP_IDCODE_EN
    localparam int RST_IR = 2;
    localparam bit IDC_EN = 1'b1;
`else
    localparam int RST_IR = 15;
    localparam bit IDC_EN = 1'b0;
`endif

    logic         TCK = 1'b0;
    logic         TRST, TMS, TDI;
    logic         dr_capture, dr_shift, dr_update, ir_tdo, tdo_sel;
    logic         bsr_select, bypass_select, idcode_select, mode, tlr_reset;
    logic [W-1:0] ir_out;

    tap_ctrl #(.IR_WIDTH(W)) dut (
        .TCK           (TCK),
        .TRST          (TRST),
        .TMS           (TMS),
        .TDI           (TDI),
        .dr_capture    (dr_capture),
        .dr_shift      (dr_shift),
        .dr_update     (dr_update),
        .ir_tdo        (ir_tdo),
        .tdo_sel       (tdo_sel),
        .bsr_select    (bsr_select),
        .bypass_select (bypass_select),
        .idcode_select (idcode_select),
        .mode          (mode),
        .tlr_reset     (tlr_reset),
        .ir_out        (ir_out)
    );

    always #5 TCK = ~TCK;

    typedef struct {
        tap_state_t   st;
        logic         cap, sh, upd, tsel, tlr, tdo, bsr, byp, idc, mode;
        logic [W-1:0] ir;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model state
    tap_state_t m_st = TLR;
    int         m_shift = 1;
    int         m_ir = RST_IR;

    function automatic void chk(input string n, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, exp, $time);
        end
    endfunction

    // IEEE 1149.1 golden transition table
    function automatic tap_state_t golden(input tap_state_t s, input logic t);
        case (s)
            TLR:     return t ? TLR    : RTI;
            RTI:     return t ? SEL_DR : RTI;
            SEL_DR:  return t ? SEL_IR : CAP_DR;
            CAP_DR:  return t ? EX1_DR : SH_DR;
            SH_DR:   return t ? EX1_DR : SH_DR;
            EX1_DR:  return t ? UPD_DR : PAU_DR;
            PAU_DR:  return t ? EX2_DR : PAU_DR;
            EX2_DR:  return t ? UPD_DR : SH_DR;
            UPD_DR:  return t ? SEL_DR : RTI;
            SEL_IR:  return t ? TLR    : CAP_IR;
            CAP_IR:  return t ? EX1_IR : SH_IR;
            SH_IR:   return t ? EX1_IR : SH_IR;
            EX1_IR:  return t ? UPD_IR : PAU_IR;
            PAU_IR:  return t ? EX2_IR : PAU_IR;
            EX2_IR:  return t ? UPD_IR : SH_IR;
            default: return t ? SEL_DR : RTI;
        endcase
    endfunction

    task automatic step(input logic trst, input logic tms, input logic tdi);
        exp_t       e;
        tap_state_t ns;
        @(negedge TCK);
        TRST = trst;
        TMS  = tms;
        TDI  = tdi;
        if (trst) begin
            m_st    = TLR;
            m_shift = 1;
            m_ir    = RST_IR;
        end else begin
            ns = golden(m_st, tms);
            if (m_st == CAP_IR)      m_shift = 1;
            else if (m_st == SH_IR)  m_shift = (m_shift >> 1) | (int'(tdi) << (W - 1));
            else if (m_st == UPD_IR) m_ir = m_shift;
            if (ns == TLR) m_ir = RST_IR;
            m_st = ns;
        end
        e.st   = m_st;
        e.cap  = (m_st == CAP_DR);
        e.sh   = (m_st == SH_DR);
        e.upd  = (m_st == UPD_DR);
        e.tlr  = (m_st == TLR);
        e.tsel = m_st inside {CAP_IR, SH_IR, EX1_IR, PAU_IR, EX2_IR, UPD_IR};
        e.tdo  = m_shift[0];
        e.ir   = m_ir[W-1:0];
        e.bsr  = (m_ir == 0) || (m_ir == 1);
        e.mode = (m_ir == 0);
        e.idc  = IDC_EN && (m_ir == 2);
        e.byp  = !(e.bsr || e.idc);
        q.push_back(e);
    endtask

    task automatic settle();
        @(posedge TCK);
        #2;
    endtask

    // From RTI: Select-IR, Capture, shift W bits (last with TMS=1), Update, RTI
    task automatic load_ir(input int val);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < W; i++) step(0, (i == W - 1), val[i]);
        step(0, 1, 0);
        step(0, 0, 0);
    endtask

    // Monitor: pops one expectation per rising edge and compares
    initial begin
        exp_t e;
        forever begin
            @(posedge TCK);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("state",      int'(dut.w_state), int'(e.st));
                chk("dr_capture", int'(dr_capture),  int'(e.cap));
                chk("dr_shift",   int'(dr_shift),    int'(e.sh));
                chk("dr_update",  int'(dr_update),   int'(e.upd));
                chk("tdo_sel",    int'(tdo_sel),     int'(e.tsel));
                chk("tlr_reset",  int'(tlr_reset),   int'(e.tlr));
                chk("ir_tdo",     int'(ir_tdo),      int'(e.tdo));
                chk("ir_out",     int'(ir_out),      int'(e.ir));
                chk("bsr_select", int'(bsr_select),  int'(e.bsr));
                chk("bypass_sel", int'(bypass_select), int'(e.byp));
                chk("idcode_sel", int'(idcode_select), int'(e.idc));
                chk("mode",       int'(mode),        int'(e.mode));
                chk("onehot", $countones({bsr_select, bypass_select, idcode_select}), 1);
            end
        end
    end

    initial begin
        string paths[16];
        paths = '{"", "0", "01", "010", "0100", "0101", "01010", "010101", "01011",
                  "011", "0110", "01100", "01101", "011010", "0110101", "011011"};
        TRST = 1'b1;
        TMS  = 1'b1;
        TDI  = 1'b0;

        // Reset
        step(1, 1, 0);
        settle();
        chk("rst_ir_out", int'(ir_out), RST_IR);
        chk("rst_tlr",    int'(tlr_reset), 1);
        chk("rst_sel",    int'(IDC_EN ? idcode_select : bypass_select), 1);

        // DR scan: capture once, shift three cycles, update after TMS=1,1
        step(0, 0, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        settle();
        chk("dr_cap_dir", int'(dr_capture), 1);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0);
            settle();
            chk("dr_sh_dir", int'({dr_capture, dr_shift, dr_update}), 3'b010);
        end
        step(0, 1, 0);
        settle();
        chk("dr_ex1_noupd", int'(dr_update), 0);
        step(0, 1, 0);
        settle();
        chk("dr_upd_dir", int'(dr_update), 1);
        step(0, 0, 0);

        // Instruction loads
        load_ir(0);
        settle();
        chk("extest_ir",   int'(ir_out), 0);
        chk("extest_mode", int'(mode), 1);
        load_ir(1);
        settle();
        chk("sample_bsr",  int'(bsr_select), 1);
        chk("sample_mode", int'(mode), 0);
        load_ir(7);
        settle();
        chk("undef_byp", int'(bypass_select), 1);
        load_ir(2);
        load_ir(15);
        load_ir(0);

        // Five TMS=1 from SH_DR reach TLR
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 1, 0);
        settle();
        chk("tms5_tlr", int'(tlr_reset), 1);
        chk("tms5_ir",  int'(ir_out), RST_IR);

        // TRST mid Shift-IR discards the pending instruction
        step(0, 0, 0);
        load_ir(1);
        step(0, 1, 0);
        step(0, 1, 0);
        step(0, 0, 0);
        step(0, 0, 1);
        step(0, 0, 1);
        step(1, 0, 1);
        settle();
        chk("trst_mid_ir",  int'(ir_out), RST_IR);
        chk("trst_mid_tlr", int'(tlr_reset), 1);
        chk("trst_mid_tdo", int'(ir_tdo), 1);

        // Full sweep: every state, both TMS values
        for (int s = 0; s < 16; s++) begin
            for (int t = 0; t < 2; t++) begin
                step(1, 1, 0);
                for (int k = 0; k < paths[s].len(); k++)
                    step(0, paths[s][k] == "1", 1'($urandom_range(0, 1)));
                step(0, t[0], 1'($urandom_range(0, 1)));
            end
        end

        // Randomized traffic
        step(1, 1, 0);
        repeat (3000) step(($urandom_range(0, 63) == 0),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

        repeat (3) @(posedge TCK);
        #2;
        chk("drain", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
